// File: rtl/coin_acceptor.sv
// Coin acceptor: synchronises the coin sensor, measures each high pulse and
// classifies it as a 5-credit coin, a 10-credit coin, a reject or a jam.
// Optional credit accumulator on port total is built when COIN_TOTAL_EN is defined.
module coin_acceptor #(
  parameter int W5_MIN   = 4,
  parameter int W5_MAX   = 7,
  parameter int W10_MIN  = 10,
  parameter int W10_MAX  = 15,
  parameter int JAM_CYC  = 64,
  parameter int LOCK_CYC = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_sense,
  output logic       credit5,
  output logic       credit10,
  output logic       reject,
  output logic       jam,
  output logic       busy
`ifdef COIN_TOTAL_EN
  ,
  output logic [7:0] total
`endif
);

  localparam int LW = (LOCK_CYC < 2) ? 1 : $clog2(LOCK_CYC + 1);

  localparam logic [6:0]    W5_LO   = 7'(W5_MIN);
  localparam logic [6:0]    W5_HI   = 7'(W5_MAX);
  localparam logic [6:0]    W10_LO  = 7'(W10_MIN);
  localparam logic [6:0]    W10_HI  = 7'(W10_MAX);
  localparam logic [6:0]    JAM_W   = 7'(JAM_CYC);
  localparam logic [LW-1:0] LOCK_LD = LW'(LOCK_CYC);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEASURE,
    ST_LOCKOUT,
    ST_JAM
  } state_e;

  state_e        state_q, state_d;
  logic          sync1_q, s_q;
  logic [6:0]    width_q, width_d;
  logic [LW-1:0] lock_q, lock_d;
  logic          credit5_q, credit5_d;
  logic          credit10_q, credit10_d;
  logic          reject_q, reject_d;
  logic [6:0]    width_inc;

  assign width_inc = width_q + 7'd1;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its inputs; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= 1'b0;
      s_q        <= 1'b0;
      state_q    <= ST_IDLE;
      width_q    <= '0;
      lock_q     <= '0;
      credit5_q  <= 1'b0;
      credit10_q <= 1'b0;
      reject_q   <= 1'b0;
    end else begin
      sync1_q    <= coin_sense;
      s_q        <= sync1_q;
      state_q    <= state_d;
      width_q    <= width_d;
      lock_q     <= lock_d;
      credit5_q  <= credit5_d;
      credit10_q <= credit10_d;
      reject_q   <= reject_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through the
  // case can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    width_d    = width_q;
    lock_d     = lock_q;
    credit5_d  = 1'b0;
    credit10_d = 1'b0;
    reject_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (s_q) begin
          state_d = ST_MEASURE;
          width_d = 7'd1;
        end
      end
      ST_MEASURE: begin
        if (s_q) begin
          width_d = width_inc;
          if (width_inc == JAM_W) state_d = ST_JAM;
        end else begin
          // Pulse is registered on the same edge that leaves MEASURE.
          if (width_q >= W5_LO && width_q <= W5_HI)        credit5_d  = 1'b1;
          else if (width_q >= W10_LO && width_q <= W10_HI) credit10_d = 1'b1;
          else                                             reject_d   = 1'b1;
          state_d = ST_LOCKOUT;
          lock_d  = LOCK_LD;
        end
      end
      ST_LOCKOUT: begin
        // A coin arriving here is never measured: we only leave once s has dropped.
        if (lock_q != '0)  lock_d  = lock_q - LW'(1);
        else if (!s_q)     state_d = ST_IDLE;
      end
      ST_JAM: begin
        if (!s_q) begin
          state_d = ST_LOCKOUT;
          lock_d  = LOCK_LD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign credit5  = credit5_q;
  assign credit10 = credit10_q;
  assign reject   = reject_q;
  assign jam      = (state_q == ST_JAM);
  assign busy     = (state_q != ST_IDLE);

`ifdef COIN_TOTAL_EN
  logic [7:0] total_q, total_d;

  // Accumulates in units of 5 credits, moving on the same edge as the credit pulse.
  always_comb begin
    total_d = total_q;
    if (credit5_d)       total_d = (total_q == 8'hFF) ? 8'hFF : total_q + 8'd1;
    else if (credit10_d) total_d = (total_q >= 8'hFE) ? 8'hFF : total_q + 8'd2;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) total_q <= 8'd0;
    else      total_q <= total_d;
  end

  assign total = total_q;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor: directed scenarios with literal
// expectations plus randomized coins compared every cycle against a reference model.
module tb_coin_acceptor;

  localparam int W5_MIN   = 4;
  localparam int W5_MAX   = 7;
  localparam int W10_MIN  = 10;
  localparam int W10_MAX  = 15;
  localparam int JAM_CYC  = 64;
  localparam int LOCK_CYC = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic coin_sense = 1'b0;
  logic credit5, credit10, reject, jam, busy;
`ifdef COIN_TOTAL_EN
  logic [7:0] total;
`endif

  coin_acceptor #(
    .W5_MIN(W5_MIN), .W5_MAX(W5_MAX), .W10_MIN(W10_MIN), .W10_MAX(W10_MAX),
    .JAM_CYC(JAM_CYC), .LOCK_CYC(LOCK_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .coin_sense(coin_sense),
    .credit5(credit5),
    .credit10(credit10),
    .reject(reject),
    .jam(jam),
    .busy(busy)
`ifdef COIN_TOTAL_EN
    ,
    .total(total)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: sensor delayed two samples; a high run is measured from
  // its first sample, a finished run is classified, then a dead time follows.
  bit m_sync1, m_s;
  int m_width;   // 0 when no coin is being measured, else samples so far
  int m_lock;    // -1 when no dead time is pending, else cycles left
  bit m_jam;
  int m_total;
  bit e_c5, e_c10, e_rej;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_sync1 = 0; m_s = 0; m_width = 0; m_lock = -1; m_jam = 0; m_total = 0;
      e_c5 = 0; e_c10 = 0; e_rej = 0;
    end else begin
      e_c5 = 0; e_c10 = 0; e_rej = 0;
      if (m_jam) begin
        if (!m_s) begin m_jam = 0; m_lock = LOCK_CYC; end
      end else if (m_width > 0) begin
        if (m_s) begin
          m_width++;
          if (m_width >= JAM_CYC) begin m_width = 0; m_jam = 1; end
        end else begin
          if (m_width >= W5_MIN && m_width <= W5_MAX) begin
            e_c5 = 1; m_total = (m_total + 1 > 255) ? 255 : m_total + 1;
          end else if (m_width >= W10_MIN && m_width <= W10_MAX) begin
            e_c10 = 1; m_total = (m_total + 2 > 255) ? 255 : m_total + 2;
          end else begin
            e_rej = 1;
          end
          m_width = 0;
          m_lock  = LOCK_CYC;
        end
      end else if (m_lock >= 0) begin
        if (m_lock > 0) m_lock--;
        else if (!m_s) m_lock = -1;
      end else if (m_s) begin
        m_width = 1;
      end
      m_s     = m_sync1;
      m_sync1 = coin_sense;
    end
  end

  int mon_c5 = 0, mon_c10 = 0, mon_rej = 0, mon_jam = 0, mon_busy = 0;

  always @(negedge clk) begin
    check("credit5", credit5, e_c5);
    check("credit10", credit10, e_c10);
    check("reject", reject, e_rej);
    check("jam", jam, m_jam);
    check("busy", busy, (m_width > 0) || (m_lock >= 0) || m_jam);
`ifdef COIN_TOTAL_EN
    check("total", total, m_total);
`endif
    check("one_hot_pulse", 32'(credit5) + 32'(credit10) + 32'(reject) <= 1, 1);
    mon_c5   += int'(credit5);
    mon_c10  += int'(credit10);
    mon_rej  += int'(reject);
    mon_jam  += int'(jam);
    mon_busy += int'(busy);
  end

  task automatic clear_mon();
    mon_c5 = 0; mon_c10 = 0; mon_rej = 0; mon_jam = 0; mon_busy = 0;
  endtask

  // Called at a negedge; leaves coin_sense low after w sampled edges.
  task automatic send_coin(input int w);
    coin_sense = 1'b1;
    repeat (w) @(negedge clk);
    coin_sense = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    repeat (4) @(negedge clk);
    i = 0;
    while (busy && i < 300) begin
      @(negedge clk);
      i++;
    end
    check("idle_timeout", busy, 0);
    repeat (2) @(negedge clk);
  endtask

  // Counts edges from the fall of coin_sense until credit5 is seen high.
  task automatic wait_c5_pulse(output int n);
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      #1;
      if (credit5) break;
    end
  endtask

  initial begin
    int n;
    bit b;
    #1 rst = 1'b0;
    #1;
    check("rst_credit5", credit5, 0);
    check("rst_credit10", credit10, 0);
    check("rst_reject", reject, 0);
    check("rst_jam", jam, 0);
    check("rst_busy", busy, 0);
`ifdef COIN_TOTAL_EN
    check("rst_total", total, 0);
`endif
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);

    // a) 5-cycle coin
    clear_mon();
    send_coin(5);
    wait_c5_pulse(n);
    check("a_latency", n, 3);
    wait_idle();
    check("a_c5", mon_c5, 1);
    check("a_other", mon_c10 + mon_rej, 0);
    check("a_busy_cycles", mon_busy, 14);
`ifdef COIN_TOTAL_EN
    check("a_total", total, 1);
`endif

    // b) 12-cycle coin
    clear_mon();
    send_coin(12);
    wait_idle();
    check("b_c10", mon_c10, 1);
    check("b_c5", mon_c5, 0);
`ifdef COIN_TOTAL_EN
    check("b_total", total, 3);
`endif

    // c) widths just outside / between / above the windows
    clear_mon();
    send_coin(3);  wait_idle();
    send_coin(8);  wait_idle();
    send_coin(16); wait_idle();
    check("c_rej", mon_rej, 3);
    check("c_credits", mon_c5 + mon_c10, 0);
`ifdef COIN_TOTAL_EN
    check("c_total", total, 3);
`endif

    // d) jammed sensor
    clear_mon();
    send_coin(70);
    wait_idle();
    check("d_jam_cycles", mon_jam, 7);
    check("d_pulses", mon_c5 + mon_c10 + mon_rej, 0);
    check("d_busy_cycles", mon_busy, 79);

    // e) second coin arrives during the dead time
    clear_mon();
    send_coin(5);
    wait_c5_pulse(n);
    repeat (2) @(negedge clk);
    send_coin(5);
    wait_idle();
    check("e_c5", mon_c5, 1);
    check("e_other", mon_c10 + mon_rej, 0);
    check("e_busy_cycles", mon_busy, 15);
`ifdef COIN_TOTAL_EN
    check("e_total", total, 4);
`endif

    // f) reset mid-measurement; coin finishes while reset is held
    clear_mon();
    coin_sense = 1'b1;
    repeat (3) @(posedge clk);
    #1 b = busy;
    check("f_busy_before_rst", b, 1);
    #1 rst = 1'b0;
    #1;
    check("f_rst_busy", busy, 0);
    check("f_rst_pulses", 32'(credit5) + 32'(credit10) + 32'(reject) + 32'(jam), 0);
`ifdef COIN_TOTAL_EN
    check("f_rst_total", total, 0);
`endif
    repeat (10) @(negedge clk);
    coin_sense = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    repeat (20) @(negedge clk);
    check("f_no_pulse", mon_c5 + mon_c10 + mon_rej, 0);

    // Sensor already high when reset releases: measured from the first high sample
    clear_mon();
    #2 rst = 1'b0;
    coin_sense = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    coin_sense = 1'b0;
    wait_idle();
    check("rel_high_c10", mon_c10, 1);
    check("rel_high_other", mon_c5 + mon_rej, 0);

    // Randomized coins, gaps and occasional mid-coin resets
    for (int k = 0; k < 150; k++) begin
      int w, gap, rst_at;
      bit do_rst;
      case ($urandom_range(0, 5))
        0: w = $urandom_range(1, 3);
        1: w = $urandom_range(W5_MIN - 1, W5_MAX + 1);
        2: w = $urandom_range(W10_MIN - 1, W10_MAX + 1);
        3: w = $urandom_range(16, JAM_CYC - 1);
        4: w = $urandom_range(JAM_CYC, JAM_CYC + 16);
        default: w = $urandom_range(1, 20);
      endcase
      do_rst = ($urandom_range(0, 19) == 0);
      rst_at = $urandom_range(0, w - 1);
      coin_sense = 1'b1;
      for (int i = 0; i < w; i++) begin
        @(negedge clk);
        if (do_rst && i == rst_at) begin
          #2 rst = 1'b0;
          @(negedge clk);
          #2 rst = 1'b1;
        end
      end
      coin_sense = 1'b0;
      gap = $urandom_range(0, 20);
      repeat (gap) @(negedge clk);
    end
    wait_idle();

    // f) saturation of the accumulator
    clear_mon();
    for (int k = 0; k < 200; k++) begin
      send_coin(12);
      wait_idle();
    end
    check("sat_c10", mon_c10, 200);
`ifdef COIN_TOTAL_EN
    check("sat_total", total, 255);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/coin_acceptor.md
COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  W5_MIN  4  minimum high-sample count classified as a 5-credit coin
  W5_MAX  7  maximum high-sample count classified as a 5-credit coin
  W10_MIN  10  minimum high-sample count classified as a 10-credit coin
  W10_MAX  15  maximum high-sample count classified as a 10-credit coin
  JAM_CYC  64  high-sample count at which the sensor is declared jammed
  LOCK_CYC  8  dead-time cycles after each coin event
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  input  1  single clock; all logic on the rising edge
  rst  input  1  reset; asynchronous, active-low
  coin_sense  input  1  raw sensor; asynchronous to clk; high while a coin passes
  credit5  output  1  one-cycle pulse; 5-credit coin accepted
  credit10  output  1  one-cycle pulse; 10-credit coin accepted
  reject  output  1  one-cycle pulse; pulse width not in either window
  jam  output  1  level; high while in JAM
  busy  output  1  level; high in any state other than IDLE
  total  output  8  accepted value in units of 5 (present only with COIN_TOTAL_EN)

Function
REQ-003 coin_sense SHALL pass through a 2-flop synchronizer; the FSM SHALL use only the second-stage output (s).
REQ-004 The FSM SHALL have exactly these states: IDLE, MEASURE, LOCKOUT, JAM.
REQ-005 IDLE, s=1: go to MEASURE and load the 7-bit width counter with 1.
REQ-006 MEASURE, s=1: increment the width counter; when the counter reaches JAM_CYC, go to JAM with no credit pulse.
REQ-007 MEASURE, s=0: classify the width counter value w and go to LOCKOUT with the lock counter loaded with LOCK_CYC.
REQ-008 Classification: W5_MIN<=w<=W5_MAX gives credit5; W10_MIN<=w<=W10_MAX gives credit10; any other w gives reject. Windows are inclusive.
REQ-009 credit5, credit10 and reject SHALL be registered and asserted on the same edge that leaves MEASURE. Each SHALL be high for exactly one cycle, and at most one SHALL be high in any cycle.
REQ-010 Latency: if coin_sense is first sampled low at edge k, the pulse SHALL be high between edges k+2 and k+3.
REQ-011 LOCKOUT: decrement the lock counter each cycle and ignore s. At zero, go to IDLE if s=0; otherwise stay in LOCKOUT until s=0. A coin in progress during lockout SHALL NOT be credited.
REQ-012 JAM: jam=1. Stay in JAM while s=1; when s=0, go to LOCKOUT (lock counter=LOCK_CYC) with no pulse.
REQ-013 busy SHALL be 1 in MEASURE, LOCKOUT and JAM, and 0 in IDLE.
REQ-014 Parameter relations SHALL hold: W5_MAX<W10_MIN<=W10_MAX<JAM_CYC<=127, and LOCK_CYC>=1.

Reset
REQ-015 rst=0 SHALL immediately force: state IDLE; synchronizer flops 0; both counters 0; credit5=credit10=reject=jam=busy=0; total=0.
REQ-016 Reset asserted mid-MEASURE SHALL discard the coin with no pulse, including after release.
REQ-017 After rst rises, a coin_sense that is already high SHALL be measured from the first cycle s=1. The resulting width SHALL be classified normally.

Configuration
REQ-018 Macro COIN_TOTAL_EN: when defined, the total port and an 8-bit accumulator SHALL exist.
REQ-019 With COIN_TOTAL_EN, the accumulator SHALL add 1 on credit5 and 2 on credit10 in the same cycle as the pulse, and SHALL saturate at 255.
REQ-020 Without COIN_TOTAL_EN, neither the total port nor the accumulator SHALL exist; all other behaviour is identical.

Verification
REQ-021 The bench SHALL cover these scenarios:
  a) coin_sense high 5 cycles -> credit5 high exactly 1 cycle, 3 edges after the fall (REQ-010); busy=1 for 2+5+8 cycles approx.; total=1.
  b) coin_sense high 12 cycles -> credit10 once; credit5=0; total=2 (cumulative 3 after a).
  c) widths 3, 8 and 16 -> reject once for each coin; no credits; total unchanged.
  d) coin_sense high 70 cycles -> jam=1 from count 64 until s=0, then LOCKOUT, then IDLE; no credit/reject.
  e) second 5-cycle coin starting 2 cycles after a credit5 -> no pulse for it; FSM returns to IDLE only after s=0.
  f) rst=0 at cycle 3 of a 12-cycle coin -> all outputs 0 immediately, no pulse ever; 200 credit10 coins -> total saturates at 255.
